// File: rtl/seq_mag_comparator_if.sv
// Handshake and operand/result bundle for the sequential magnitude comparator.
// The master issues compares; the slave (the comparator) returns the result flags.
interface seq_mag_comparator_if #(
   parameter int WIDTH = 16
);
   logic             start;
   logic             signed_mode;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic             busy;
   logic             done;
   logic             AgB;
   logic             AlB;
   logic             AeqB;

   modport master (
      output start, signed_mode, A, B,
      input  busy, done, AgB, AlB, AeqB
   );

   modport slave (
      input  start, signed_mode, A, B,
      output busy, done, AgB, AlB, AeqB
   );
endinterface

// File: rtl/seq_mag_comparator.sv
// Multi-cycle MSB-first magnitude comparator: one DIGIT-bit slice per clock,
// early exit on the first differing slice, unsigned or two's-complement.
//
//   state | meaning
//   IDLE  | waiting for start; results hold last compare
//   RUN   | comparing slice idx of the latched operands
module seq_mag_comparator #(
   parameter int WIDTH = 16,
   parameter int DIGIT = 2
) (
   input logic               clk,
   input logic               rst,
   seq_mag_comparator_if.slave bus
);

   localparam int NSLICE = WIDTH / DIGIT;
   localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLICE - 1);
   localparam logic [WIDTH-1:0] MSB_MASK = WIDTH'(1) << (WIDTH - 1);

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   state_t           state, state_nxt;
   logic [IDX_W-1:0] idx, idx_nxt;
   logic [WIDTH-1:0] a_sh, a_nxt;
   logic [WIDTH-1:0] b_sh, b_nxt;
   logic             done_r, done_nxt;
   logic             agb, agb_nxt;
   logic             alb, alb_nxt;
   logic             aeqb, aeqb_nxt;

   logic [DIGIT-1:0] slice_a;
   logic [DIGIT-1:0] slice_b;
   logic [WIDTH-1:0] sign_flip;

   // Operands are shifted left each cycle so the live slice is always the top
   // DIGIT bits, avoiding a WIDTH-wide slice multiplexer.
   assign slice_a   = a_sh[WIDTH-1 -: DIGIT];
   assign slice_b   = b_sh[WIDTH-1 -: DIGIT];

   // Flipping the sign bit maps two's-complement order onto unsigned order;
   // only slice 0 contains that bit, so the rest compare unsigned naturally.
   assign sign_flip = bus.signed_mode ? MSB_MASK : '0;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= IDLE;
         idx    <= '0;
         a_sh   <= '0;
         b_sh   <= '0;
         done_r <= 1'b0;
         agb    <= 1'b0;
         alb    <= 1'b0;
         aeqb   <= 1'b0;
      end else begin
         state  <= state_nxt;
         idx    <= idx_nxt;
         a_sh   <= a_nxt;
         b_sh   <= b_nxt;
         done_r <= done_nxt;
         agb    <= agb_nxt;
         alb    <= alb_nxt;
         aeqb   <= aeqb_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      idx_nxt   = idx;
      a_nxt     = a_sh;
      b_nxt     = b_sh;
      done_nxt  = 1'b0;
      agb_nxt   = agb;
      alb_nxt   = alb;
      aeqb_nxt  = aeqb;

      case (state)
         IDLE: begin
            if (bus.start) begin
               a_nxt     = bus.A ^ sign_flip;
               b_nxt     = bus.B ^ sign_flip;
               idx_nxt   = '0;
               state_nxt = RUN;
            end
         end

         RUN: begin
            if (slice_a != slice_b) begin
               agb_nxt   = (slice_a > slice_b);
               alb_nxt   = (slice_a < slice_b);
               aeqb_nxt  = 1'b0;
               done_nxt  = 1'b1;
               state_nxt = IDLE;
            end else if (idx == LAST_IDX) begin
               agb_nxt   = 1'b0;
               alb_nxt   = 1'b0;
               aeqb_nxt  = 1'b1;
               done_nxt  = 1'b1;
               state_nxt = IDLE;
            end else begin
               idx_nxt = idx + IDX_W'(1);
               a_nxt   = a_sh << DIGIT;
               b_nxt   = b_sh << DIGIT;
            end
         end

         default: state_nxt = IDLE;
      endcase
   end

   assign bus.busy = (state == RUN);
   assign bus.done = done_r;
   assign bus.AgB  = agb;
   assign bus.AlB  = alb;
   assign bus.AeqB = aeqb;

endmodule

// File: tb/tb_seq_mag_comparator.sv
// Scoreboard bench for seq_mag_comparator: directed cases plus random compares,
// checked against an integer-arithmetic reference model.
module tb_seq_mag_comparator;

   localparam int WIDTH  = 16;
   localparam int DIGIT  = 2;
   localparam int NSLICE = WIDTH / DIGIT;

   typedef struct {
      logic gt;
      logic lt;
      logic eq;
      int   lat;
      int   t0;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   seq_mag_comparator_if #(.WIDTH(WIDTH)) bus ();
   seq_mag_comparator #(.WIDTH(WIDTH), .DIGIT(DIGIT)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   exp_t       sb[$];
   int         errors = 0;
   int         checks = 0;
   int         ncyc   = 0;
   logic [2:0] exp_res = 3'b000;
   logic       prev_done = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                  input logic sm);
      exp_t             e;
      longint           va, vb;
      logic [WIDTH-1:0] x;
      int               sl;
      if (sm) begin
         va = longint'($signed(a));
         vb = longint'($signed(b));
      end else begin
         va = longint'({1'b0, a});
         vb = longint'({1'b0, b});
      end
      e.gt  = (va > vb);
      e.lt  = (va < vb);
      e.eq  = (va == vb);
      e.t0  = 0;
      e.lat = NSLICE;
      x = a ^ b;
      for (int j = 0; j < NSLICE; j++) begin
         sl = int'(x >> (WIDTH - (j + 1) * DIGIT)) % (1 << DIGIT);
         if (sl != 0) begin
            e.lat = j + 1;
            break;
         end
      end
      return e;
   endfunction

   // Monitor: pops the scoreboard whenever done is presented.
   always @(negedge clk) begin
      exp_t e;
      ncyc++;
      if (!rst) begin
         if (bus.done) begin
            check("done_width", 32'(prev_done), 32'd0);
            check("busy_with_done", 32'(bus.busy), 32'd0);
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_done: got done=1 expected no pending compare at %0t", $time);
            end else begin
               e = sb.pop_front();
               check("result", 32'({bus.AgB, bus.AlB, bus.AeqB}), 32'({e.gt, e.lt, e.eq}));
               check("latency", 32'(ncyc - e.t0 - 1), 32'(e.lat));
               exp_res = {e.gt, e.lt, e.eq};
            end
         end else begin
            check("result_hold", 32'({bus.AgB, bus.AlB, bus.AeqB}), 32'(exp_res));
         end
      end
      prev_done = bus.done;
   end

   // Issue a compare; caller guarantees the DUT is idle at the next edge.
   task automatic do_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic sm);
      exp_t e;
      bus.A           = a;
      bus.B           = b;
      bus.signed_mode = sm;
      bus.start       = 1'b1;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      e    = model(a, b, sm);
      e.t0 = ncyc;
      sb.push_back(e);
      check("busy_after_start", 32'(bus.busy), 32'd1);
   endtask

   task automatic wait_done();
      bit seen = 1'b0;
      for (int i = 0; i < NSLICE + 4; i++) begin
         @(posedge clk);
         #1;
         if (bus.done) begin
            seen = 1'b1;
            break;
         end
      end
      if (!seen) begin
         checks++;
         errors++;
         $display("FAIL done_timeout: got no done expected done within %0d cycles", NSLICE + 4);
      end
   endtask

   initial begin
      logic [WIDTH-1:0] ra, rb;
      bus.start       = 1'b0;
      bus.signed_mode = 1'b0;
      bus.A           = '0;
      bus.B           = '0;

      #1;
      check("reset_state", 32'({bus.busy, bus.done, bus.AgB, bus.AlB, bus.AeqB}), 32'd0);
      #11 rst = 1'b0;
      @(posedge clk);
      #1;

      do_op(16'h1234, 16'h1234, 1'b0); wait_done();
      do_op(16'h8000, 16'h7FFF, 1'b0); wait_done();
      do_op(16'h8000, 16'h7FFF, 1'b1); wait_done();
      do_op(16'h00F0, 16'h0100, 1'b0); wait_done();
      do_op(16'h1235, 16'h1234, 1'b0); wait_done();

      // Start and operand changes mid-run must not disturb the compare in flight.
      do_op(16'hFFFF, 16'hFFFE, 1'b1);
      @(posedge clk); #1;
      bus.A = 16'h0000; bus.B = 16'hFFFF; bus.signed_mode = 1'b0; bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      wait_done();
      // Back-to-back start in the done cycle.
      do_op(16'h0001, 16'h0002, 1'b0); wait_done();
      @(posedge clk); #1;
      check("idle_after_done", 32'(bus.busy), 32'd0);

      // Asynchronous reset mid-compare.
      do_op(16'h5A5A, 16'h5A5A, 1'b0);
      @(posedge clk);
      @(posedge clk);
      #3 rst = 1'b1;
      #1;
      check("rst_abort", 32'({bus.busy, bus.done, bus.AgB, bus.AlB, bus.AeqB}), 32'd0);
      sb.delete();
      exp_res = 3'b000;
      @(posedge clk);
      #2 rst = 1'b0;
      @(posedge clk); #1;
      do_op(16'h7FFF, 16'h8000, 1'b1); wait_done();

      for (int n = 0; n < 200; n++) begin
         ra = WIDTH'($urandom);
         case ($urandom_range(0, 3))
            0:       rb = ra;
            1:       rb = ra ^ (WIDTH'(1) << $urandom_range(0, WIDTH - 1));
            default: rb = WIDTH'($urandom);
         endcase
         do_op(ra, rb, 1'($urandom_range(0, 1)));
         wait_done();
         if ($urandom_range(0, 2) == 0) begin
            @(posedge clk); #1;
         end
      end

      repeat (4) @(posedge clk);
      #1;
      check("scoreboard_empty", 32'(sb.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
